alu_req_sequencer: RTL and testbench
====================================

ALU_REQ_SEQUENCER -- requirements
Module: alu_req_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, response buffer entries and max outstanding ops (power of 2, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, width of request/response tag.
REQ-003 SHALL have port clk  in  1  the single clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, the request handshake.
REQ-006 SHALL have ports req_a in 8, req_b in 8, req_op in 3, req_cin in 1, req_tag in TAG_W, the request payload.
REQ-007 SHALL have ports alu_a out 8, alu_b out 8, alu_op out 3, alu_cin out 1, the ALU operand drive.
REQ-008 SHALL have ports alu_result in 16, alu_cout in 1, alu_zflag in 1, the ALU registered outputs.
REQ-009 SHALL have ports rsp_valid out 1, rsp_ready in 1, the response handshake.
REQ-010 SHALL have ports rsp_result out 16, rsp_cout out 1, rsp_zflag out 1, rsp_err out 1, rsp_tag out TAG_W, the response payload.

Function
REQ-011 SHALL accept a request on any rising edge where req_valid && req_ready (transfer = "issue").
REQ-012 SHALL load alu_a/b/op/cin from req_* registers on issue; without issue, alu_* hold their last value.
REQ-013 SHALL track in-flight ops in a 2-stage valid/tag/err pipeline: stage1 set on issue edge k, stage2 at edge k+1.
REQ-014 SHALL capture alu_result/cout/zflag plus stage2 tag/err into response buffer at edge k+2; no capture for bubbles.
REQ-015 SHALL make rsp_valid high in the cycle after edge k+2 if the buffer was empty and no earlier entry is pending (min latency 2 edges).
REQ-016 SHALL compute err at issue: 1 when req_op==3'b011 && req_b==0, or req_op in {3'b110,3'b111}; else 0.
REQ-017 SHALL pass ALU values unmodified; err never alters result/cout/zflag.
REQ-018 SHALL drive req_ready = (buffer count + in-flight count) < DEPTH, combinational from registers only (no dependence on req_valid).
REQ-019 SHALL never overflow the response buffer; credit rule of REQ-018 guarantees space at capture.
REQ-020 SHALL present buffer head on rsp_*; pop on rising edge where rsp_valid && rsp_ready.
REQ-021 SHALL keep rsp_* payload stable while rsp_valid && !rsp_ready.
REQ-022 SHALL return responses strictly in issue order; tags are opaque and unchecked.
REQ-023 SHALL handle simultaneous capture and pop: count unchanged, both pointers advance; empty-buffer capture+pop not required (rsp_valid low that cycle).
REQ-024 SHALL wrap buffer pointers modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-025 SHALL sustain one issue per cycle when rsp_ready is held high (full throughput).

Reset
REQ-026 SHALL on rst_n low asynchronously clear: alu_a/b/op/cin=0, pipeline valids=0, buffer count/pointers=0, rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_zflag=0, rsp_err=0, rsp_tag=0.
REQ-027 SHALL have req_ready=1 while and after reset (empty buffer, nothing in flight).
REQ-028 SHALL discard in-flight and buffered ops on reset mid-operation; no response emitted for them after release.
REQ-029 SHALL accept a request on the first rising edge after rst_n deasserts.

Verification
REQ-030 Add: a=200,b=100,op=000,cin=1,tag=3 issued edge k, rsp_ready=1 -> rsp_valid after edge k+2, result=0x012D, cout=1, zflag=0, err=0, tag=3.
REQ-031 Div by zero: a=0x37,b=0,op=011 -> result=0x0000, zflag=1, err=1; then a=0x37,b=5 -> result=0x000B, err=0.
REQ-032 Illegal op: op=110,a=0xFF,b=0xFF -> result=0, zflag=1, err=1.
REQ-033 Backpressure: rsp_ready=0, 6 back-to-back requests tags 0..5 -> exactly 4 accepted, req_ready=0 after 4th; raise rsp_ready -> tags 0,1,2,3 then 4,5 in order, payload stable while stalled.
REQ-034 Streaming: 16 requests, rsp_ready=1 -> one issue per cycle, 16 responses in order, no bubbles after first.
REQ-035 Reset mid-op: 3 ops in flight, pulse rst_n low between edges -> all outputs at REQ-026 values immediately, req_ready=1, zero responses afterwards until new issue.

Source files
------------

// File: rtl/alu_req_sequencer_if.sv
// alu_req_sequencer_if: request and response handshake bundle for alu_req_sequencer.
interface alu_req_sequencer_if #(parameter int TAG_W = 4);
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_a;
    logic [7:0]       req_b;
    logic [2:0]       req_op;
    logic             req_cin;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_result;
    logic             rsp_cout;
    logic             rsp_zflag;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    modport master (
        output req_valid, req_a, req_b, req_op, req_cin, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zflag, rsp_err, rsp_tag
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, req_cin, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_zflag, rsp_err, rsp_tag
    );
endinterface

// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer: issues requests to an external registered ALU, tracks them through a
// two-stage in-flight pipeline and returns results in order via a credit-limited response buffer.
module alu_req_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_req_sequencer_if.slave   bus,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [2:0]           alu_op,
    output logic                 alu_cin,
    input  logic [15:0]          alu_result,
    input  logic                 alu_cout,
    input  logic                 alu_zflag
);
    localparam int PW = $clog2(DEPTH);
    typedef struct packed {
        logic [15:0]      result;
        logic             cout;
        logic             zflag;
        logic             err;
        logic [TAG_W-1:0] tag;
    } entry_t;
    entry_t           mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             s1_v;
    logic             s2_v;
    logic             s1_err;
    logic             s2_err;
    logic [TAG_W-1:0] s1_tag;
    logic [TAG_W-1:0] s2_tag;
    logic [PW+1:0]    used;
    logic             issue;
    logic             pop;
    logic             err_in;
    // Credits cover both buffered and in-flight ops, so a capture always finds a free slot.
    assign used          = {1'b0, count} + (PW+2)'(s1_v) + (PW+2)'(s2_v);
    assign bus.req_ready = used < (PW+2)'(DEPTH);
    assign issue         = bus.req_valid && bus.req_ready;
    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign err_in        = (bus.req_op == 3'b011 && bus.req_b == 8'd0) || bus.req_op[2:1] == 2'b11;
    assign bus.rsp_valid  = count != '0;
    assign bus.rsp_result = mem[rd_ptr].result;
    assign bus.rsp_cout   = mem[rd_ptr].cout;
    assign bus.rsp_zflag  = mem[rd_ptr].zflag;
    assign bus.rsp_err    = mem[rd_ptr].err;
    assign bus.rsp_tag    = mem[rd_ptr].tag;
    // Buffer entries are cleared on reset so the head reads as zero until the first capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            alu_cin <= 1'b0;
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s1_err  <= 1'b0;
            s2_err  <= 1'b0;
            s1_tag  <= '0;
            s2_tag  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (issue) begin
                alu_a   <= bus.req_a;
                alu_b   <= bus.req_b;
                alu_op  <= bus.req_op;
                alu_cin <= bus.req_cin;
            end
            s1_v   <= issue;
            s1_err <= err_in;
            s1_tag <= bus.req_tag;
            s2_v   <= s1_v;
            s2_err <= s1_err;
            s2_tag <= s1_tag;
            if (s2_v) begin
                mem[wr_ptr] <= {alu_result, alu_cout, alu_zflag, s2_err, s2_tag};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(s2_v) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_alu_req_sequencer.sv
// tb_alu_req_sequencer: scoreboard bench with a registered ALU stub and an abstract response model.
module tb_alu_req_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_cin;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        alu_zflag;
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          cyc = 0;
    int          n_issued = 0;
    int          n_rsp = 0;
    int          n_flushed = 0;
    logic        rnd_done;

    typedef struct {
        logic [15:0] result;
        logic        cout;
        logic        zflag;
        logic        err;
        logic [3:0]  tag;
        logic        lat;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    alu_req_sequencer_if #(.TAG_W(4)) bus ();

    alu_req_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .alu_zflag  (alu_zflag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU semantics: add/sub/mul/div/and/or; ops 110/111 yield zero.
    function automatic logic [17:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op, input logic cin);
        logic [15:0] r;
        logic        c;
        r = '0;
        c = 1'b0;
        case (op)
            3'd0: begin r = 16'(a) + 16'(b) + 16'(cin); c = r[8]; end
            3'd1: begin r = {8'h00, a - b - 8'(cin)}; c = int'(a) < int'(b) + int'(cin); end
            3'd2: r = 16'(a) * 16'(b);
            3'd3: r = (b == 8'd0) ? 16'h0000 : 16'(a / b);
            3'd4: r = {8'h00, a & b};
            3'd5: r = {8'h00, a | b};
            default: r = '0;
        endcase
        return {c, r == 16'h0000, r};
    endfunction

    always @(posedge clk) {alu_cout, alu_zflag, alu_result} <= alu_calc(alu_a, alu_b, alu_op, alu_cin);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic cin, input logic [3:0] tag, input logic lat, output int waited);
        exp_t        e;
        logic [17:0] r;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        bus.req_cin   = cin;
        bus.req_tag   = tag;
        waited = 0;
        while (!bus.req_ready && waited < 500) begin
            tick();
            waited++;
        end
        if (!bus.req_ready) begin
            check("req_ready timeout", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        r = alu_calc(a, b, op, cin);
        e.result = r[15:0];
        e.zflag  = r[16];
        e.cout   = r[17];
        e.err    = (op == 3'd3 && b == 8'd0) || op >= 3'd6;
        e.tag    = tag;
        e.lat    = lat;
        e.cyc    = cyc;
        exp_q.push_back(e);
        n_issued++;
        tick();
        bus.req_valid = 1'b0;
        check("alu_a", 32'(alu_a), 32'(a));
        check("alu_b", 32'(alu_b), 32'(b));
        check("alu_op", 32'(alu_op), 32'(op));
        check("alu_cin", 32'(alu_cin), 32'(cin));
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) tick();
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst alu_a", 32'(alu_a), 32'd0);
        check("rst alu_b", 32'(alu_b), 32'd0);
        check("rst alu_op", 32'(alu_op), 32'd0);
        check("rst alu_cin", 32'(alu_cin), 32'd0);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst rsp_result", 32'(bus.rsp_result), 32'd0);
        check("rst rsp_cout", 32'(bus.rsp_cout), 32'd0);
        check("rst rsp_zflag", 32'(bus.rsp_zflag), 32'd0);
        check("rst rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst rsp_tag", 32'(bus.rsp_tag), 32'd0);
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    // Monitor: every presented response is compared with the queue head; pops only on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious rsp_valid", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = exp_q[0];
                check("rsp_result", 32'(bus.rsp_result), 32'(e.result));
                check("rsp_cout", 32'(bus.rsp_cout), 32'(e.cout));
                check("rsp_zflag", 32'(bus.rsp_zflag), 32'(e.zflag));
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
                if (bus.rsp_ready) begin
                    if (e.lat) check("rsp latency", 32'(cyc - e.cyc), 32'd3);
                    void'(exp_q.pop_front());
                    n_rsp++;
                end
            end
        end
    end

    initial begin
        int w;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.req_cin   = 1'b0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;
        rnd_done      = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;
        // Directed: add, divide by zero then legal divide, illegal op.
        send(8'd200, 8'd100, 3'b000, 1'b1, 4'd3, 1'b1, w);
        drain();
        send(8'h37, 8'h00, 3'b011, 1'b0, 4'd1, 1'b1, w);
        send(8'h37, 8'h05, 3'b011, 1'b0, 4'd2, 1'b1, w);
        drain();
        send(8'hFF, 8'hFF, 3'b110, 1'b0, 4'd7, 1'b1, w);
        send(8'h12, 8'h34, 3'b111, 1'b1, 4'd8, 1'b1, w);
        drain();
        // Backpressure: four credits, then the fifth request stalls until responses drain.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'(8'd10 * i + 1), 8'(i + 2), 3'(i), 1'(i), 4'(i), 1'b0, w);
            check("bp accept", 32'(w), 32'd0);
        end
        check("bp req_ready low", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b1;
        bus.req_tag   = 4'd4;
        repeat (5) tick();
        check("bp still full", 32'(bus.req_ready), 32'd0);
        check("bp issued", 32'(n_issued), 32'd9);
        bus.rsp_ready = 1'b1;
        send(8'h44, 8'h11, 3'b001, 1'b1, 4'd4, 1'b0, w);
        send(8'h55, 8'h22, 3'b010, 1'b0, 4'd5, 1'b0, w);
        drain();
        // Streaming: one issue per cycle, each response exactly three cycles after issue.
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 5)), 1'($urandom), 4'(i), 1'b1, w);
            check("stream ready", 32'(w), 32'd0);
        end
        drain();
        // Random traffic with random response backpressure.
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send(8'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
                         3'($urandom), 1'($urandom), 4'($urandom), 1'b0, w);
                    if ($urandom_range(0, 3) == 0) tick();
                end
                rnd_done = 1'b1;
            end
            while (!rnd_done) begin
                bus.rsp_ready = $urandom_range(0, 3) != 0;
                tick();
            end
        join
        bus.rsp_ready = 1'b1;
        drain();
        // Reset mid-operation: three ops in flight are discarded.
        bus.rsp_ready = 1'b0;
        send(8'd1, 8'd2, 3'b000, 1'b0, 4'd9, 1'b0, w);
        bus.req_valid = 1'b1;
        send(8'd3, 8'd4, 3'b000, 1'b0, 4'd10, 1'b0, w);
        send(8'd5, 8'd6, 3'b000, 1'b0, 4'd11, 1'b0, w);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        n_flushed += exp_q.size();
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post-reset quiet", 32'(bus.rsp_valid), 32'd0);
        end
        send(8'd200, 8'd100, 3'b000, 1'b1, 4'd3, 1'b1, w);
        check("post-reset ready", 32'(w), 32'd0);
        drain();
        check("response count", 32'(n_rsp), 32'(n_issued - n_flushed));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
